// File: rtl/ram_arbiter_if.sv
// Requester-side handshake bundle for ram_arbiter: one instance per master.
// The master drives req/we/addr/wdata; the arbiter returns gnt/rvalid/rdata.
interface ram_arbiter_if #(
   parameter int WIDTH  = 8,
   parameter int A_SIZE = 8
);
   logic              req;
   logic              we;
   logic [A_SIZE-1:0] addr;
   logic [WIDTH-1:0]  wdata;
   logic              gnt;
   logic              rvalid;
   logic [WIDTH-1:0]  rdata;

   modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_arbiter.sv
// Two-master arbiter/sequencer for the single-port ram; serialises single-word reads/writes.
// Define RAM_ARB_FIXED_PRIO_EN for fixed priority (m0 wins ties); default is round-robin.
module ram_arbiter #(
   parameter int WIDTH  = 8,
   parameter int A_SIZE = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   ram_arbiter_if.slave      m0,
   ram_arbiter_if.slave      m1,
   output logic [A_SIZE-1:0] ram_addr,
   inout  wire  [WIDTH-1:0]  ram_data,
   output logic              ram_write,
   output logic              ram_en
);

   typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_t;

   state_t            state, state_n;
   logic              owner, owner_n;
   logic              pick;
   logic [WIDTH-1:0]  wdata_q, wdata_n;
   logic              drive_q, drive_n;
   logic [A_SIZE-1:0] addr_n;
   logic              write_n, en_n;
   logic [1:0]        gnt_q, gnt_n;
   logic [1:0]        rvalid_q, rvalid_n;
   logic [WIDTH-1:0]  rdata0_q, rdata0_n, rdata1_q, rdata1_n;
`ifndef RAM_ARB_FIXED_PRIO_EN
   logic              ptr, ptr_n;
`endif

   // Bus is only ever driven during a write ACCESS cycle; the ram drives it otherwise.
   assign ram_data = drive_q ? wdata_q : 'z;

   assign m0.gnt    = gnt_q[0];
   assign m1.gnt    = gnt_q[1];
   assign m0.rvalid = rvalid_q[0];
   assign m1.rvalid = rvalid_q[1];
   assign m0.rdata  = rdata0_q;
   assign m1.rdata  = rdata1_q;

   always_comb begin
      state_n  = state;
      owner_n  = owner;
      wdata_n  = wdata_q;
      drive_n  = 1'b0;
      addr_n   = ram_addr;
      write_n  = 1'b0;
      en_n     = 1'b0;
      gnt_n    = '0;
      rvalid_n = '0;
      rdata0_n = rdata0_q;
      rdata1_n = rdata1_q;
`ifdef RAM_ARB_FIXED_PRIO_EN
      pick     = ~m0.req;
`else
      ptr_n    = ptr;
      pick     = (m0.req && m1.req) ? ptr : m1.req;
`endif
      case (state)
         IDLE: begin
            if (m0.req || m1.req) begin
               state_n = ACCESS;
               owner_n = pick;
               en_n    = 1'b1;
               if (pick) begin
                  write_n = m1.we;
                  addr_n  = m1.addr;
                  wdata_n = m1.wdata;
                  gnt_n   = 2'b10;
               end else begin
                  write_n = m0.we;
                  addr_n  = m0.addr;
                  wdata_n = m0.wdata;
                  gnt_n   = 2'b01;
               end
               drive_n = write_n;
`ifndef RAM_ARB_FIXED_PRIO_EN
               if (m0.req && m1.req) ptr_n = ~ptr;
`endif
            end
         end
         ACCESS: begin
            if (ram_write) begin
               state_n = IDLE;
            end else begin
               state_n = CAPTURE;
               en_n    = 1'b1;
            end
         end
         CAPTURE: begin
            state_n = IDLE;
            if (owner) begin
               rvalid_n = 2'b10;
               rdata1_n = ram_data;
            end else begin
               rvalid_n = 2'b01;
               rdata0_n = ram_data;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         owner     <= 1'b0;
         wdata_q   <= '0;
         drive_q   <= 1'b0;
         ram_addr  <= '0;
         ram_write <= 1'b0;
         ram_en    <= 1'b0;
         gnt_q     <= '0;
         rvalid_q  <= '0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
         ptr       <= 1'b0;
`endif
      end else begin
         state     <= state_n;
         owner     <= owner_n;
         wdata_q   <= wdata_n;
         drive_q   <= drive_n;
         ram_addr  <= addr_n;
         ram_write <= write_n;
         ram_en    <= en_n;
         gnt_q     <= gnt_n;
         rvalid_q  <= rvalid_n;
         rdata0_q  <= rdata0_n;
         rdata1_q  <= rdata1_n;
`ifndef RAM_ARB_FIXED_PRIO_EN
         ptr       <= ptr_n;
`endif
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural single-port ram on the shared bus.
// Grant order and read data are queued when stimulus is driven and checked as the DUT responds.
module tb_ram_arbiter;
   localparam int WIDTH  = 8;
   localparam int A_SIZE = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ram_arbiter_if #(.WIDTH(WIDTH), .A_SIZE(A_SIZE)) m0_if ();
   ram_arbiter_if #(.WIDTH(WIDTH), .A_SIZE(A_SIZE)) m1_if ();

   wire  [WIDTH-1:0]  ram_data;
   logic [A_SIZE-1:0] ram_addr;
   logic              ram_write;
   logic              ram_en;

   ram_arbiter #(.WIDTH(WIDTH), .A_SIZE(A_SIZE)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .m0        (m0_if),
      .m1        (m1_if),
      .ram_addr  (ram_addr),
      .ram_data  (ram_data),
      .ram_write (ram_write),
      .ram_en    (ram_en)
   );

   // Synchronous-read ram: data registered at the end of ACCESS, driven during CAPTURE.
   logic [WIDTH-1:0] mem [256];
   logic [WIDTH-1:0] dout;
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_write) mem[ram_addr] <= ram_data;
         else           dout <= mem[ram_addr];
      end
   end
   assign ram_data = (ram_en && !ram_write) ? dout : 'z;

   int total = 0;
   int bad   = 0;
   int gq [$];
   logic [WIDTH-1:0] rq0 [$];
   logic [WIDTH-1:0] rq1 [$];

   typedef struct {
      bit         r0;
      bit         we0;
      logic [7:0] a0;
      logic [7:0] d0;
      logic [7:0] e0;
      bit         r1;
      bit         we1;
      logic [7:0] a1;
      logic [7:0] d1;
      logic [7:0] e1;
      int         first;
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic flag(input string name);
      total++;
      bad++;
      $display("FAIL %s actual=event required=none at %0t", name, $time);
   endtask

   // Scoreboard monitor, sampled on the falling edge.
   always @(negedge clk) begin
      int e;
      if (m0_if.gnt || m1_if.gnt) begin
         check("gnt_exclusive", int'(m0_if.gnt && m1_if.gnt), 0);
         if (gq.size() == 0) flag("gnt_unexpected");
         else begin
            e = gq.pop_front();
            check("gnt_order", int'(m1_if.gnt), e);
         end
      end
      if (m0_if.rvalid || m1_if.rvalid) begin
         check("rvalid_exclusive", int'(m0_if.rvalid && m1_if.rvalid), 0);
         if (m0_if.rvalid) begin
            if (rq0.size() == 0) flag("m0_rvalid_unexpected");
            else check("m0_rdata", int'(m0_if.rdata), int'(rq0.pop_front()));
         end
         if (m1_if.rvalid) begin
            if (rq1.size() == 0) flag("m1_rvalid_unexpected");
            else check("m1_rdata", int'(m1_if.rdata), int'(rq1.pop_front()));
         end
      end
      if (!ram_en) check("bus_idle_z", int'(ram_data), 0);
      if (ram_write && !ram_en) flag("write_without_en");
   end

   task automatic set_m(input int m, input bit req, input bit we, input logic [7:0] a, input logic [7:0] d);
      if (m == 0) begin
         m0_if.req = req; m0_if.we = we; m0_if.addr = a; m0_if.wdata = d;
      end else begin
         m1_if.req = req; m1_if.we = we; m1_if.addr = a; m1_if.wdata = d;
      end
   endtask

   task automatic request(input int m, input bit we, input logic [7:0] a, input logic [7:0] d, input bit keep);
      bit got = 1'b0;
      set_m(m, 1'b1, we, a, d);
      for (int i = 0; i < 64 && !got; i++) begin
         @(negedge clk);
         got = (m == 0) ? m0_if.gnt : m1_if.gnt;
      end
      check("gnt_timeout", int'(got), 1);
      @(posedge clk);
      #1;
      if (!keep) set_m(m, 1'b0, 1'b0, 8'h00, 8'h00);
   endtask

   task automatic drain();
      for (int i = 0; i < 16 && (rq0.size() != 0 || rq1.size() != 0); i++) begin
         @(negedge clk);
         #1;
      end
      check("rvalid_timeout", rq0.size() + rq1.size(), 0);
      check("gnt_missing", gq.size(), 0);
   endtask

   task automatic apply_vec(input vec_t v);
      if (v.r0 && v.r1) begin
         gq.push_back(v.first);
         gq.push_back(1 - v.first);
      end else if (v.r0) gq.push_back(0);
      else if (v.r1) gq.push_back(1);
      if (v.r0 && !v.we0) rq0.push_back(v.e0);
      if (v.r1 && !v.we1) rq1.push_back(v.e1);
      fork
         if (v.r0) request(0, v.we0, v.a0, v.d0, 1'b0);
         if (v.r1) request(1, v.we1, v.a1, v.d1, 1'b0);
      join
      drain();
   endtask

   task automatic reset_checks();
      check("rst_m0_gnt", int'(m0_if.gnt), 0);
      check("rst_m1_gnt", int'(m1_if.gnt), 0);
      check("rst_m0_rvalid", int'(m0_if.rvalid), 0);
      check("rst_m1_rvalid", int'(m1_if.rvalid), 0);
      check("rst_m0_rdata", int'(m0_if.rdata), 0);
      check("rst_m1_rdata", int'(m1_if.rdata), 0);
      check("rst_ram_en", int'(ram_en), 0);
      check("rst_ram_write", int'(ram_write), 0);
      check("rst_ram_addr", int'(ram_addr), 0);
      check("rst_ram_data_z", int'(ram_data), 0);
   endtask

   function automatic vec_t mk(input bit r0, input bit we0, input logic [7:0] a0, input logic [7:0] d0,
                               input logic [7:0] e0, input bit r1, input bit we1, input logic [7:0] a1,
                               input logic [7:0] d1, input logic [7:0] e1, input int first);
      vec_t v;
      v.r0 = r0; v.we0 = we0; v.a0 = a0; v.d0 = d0; v.e0 = e0;
      v.r1 = r1; v.we1 = we1; v.a1 = a1; v.d1 = d1; v.e1 = e1;
      v.first = first;
      return v;
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [8];
      bit   got;
      int   tie_first;
`ifdef RAM_ARB_FIXED_PRIO_EN
      tie_first = 0;
`else
      tie_first = 1;
`endif
      vecs[0] = mk(1'b1, 1'b1, 8'h05, 8'hA5, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 0);
      vecs[1] = mk(1'b1, 1'b0, 8'h05, 8'h00, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 0);
      vecs[2] = mk(1'b1, 1'b1, 8'h10, 8'h11, 8'h00, 1'b1, 1'b1, 8'h20, 8'h22, 8'h00, 0);
      vecs[3] = mk(1'b1, 1'b0, 8'h10, 8'h00, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 0);
      vecs[4] = mk(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00, 8'h22, 0);
      vecs[5] = mk(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 8'h5C, 8'h00, 0);
      vecs[6] = mk(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h00, 8'h5C, 0);
      vecs[7] = mk(1'b1, 1'b0, 8'h05, 8'h00, 8'hA5, 1'b1, 1'b0, 8'h10, 8'h00, 8'h11, tie_first);

      set_m(0, 1'b0, 1'b0, 8'h00, 8'h00);
      set_m(1, 1'b0, 1'b0, 8'h00, 8'h00);
      repeat (3) @(negedge clk);
      reset_checks();
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) apply_vec(vecs[i]);

      // Reset asserted while an m0 read sits in CAPTURE: the read must vanish.
      gq.push_back(0);
      set_m(0, 1'b1, 1'b0, 8'h05, 8'h00);
      got = 1'b0;
      for (int i = 0; i < 64 && !got; i++) begin
         @(negedge clk);
         got = m0_if.gnt;
      end
      check("abort_gnt_timeout", int'(got), 1);
      @(posedge clk);
      #1;
      set_m(0, 1'b0, 1'b0, 8'h00, 8'h00);
      #2;
      rst_n = 1'b0;
      @(negedge clk);
      reset_checks();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      apply_vec(mk(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h33, 8'h77, 8'h00, 0));
      apply_vec(mk(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h33, 8'h00, 8'h77, 0));

      // Both masters hold req back-to-back for three writes each.
`ifdef RAM_ARB_FIXED_PRIO_EN
      gq.push_back(0); gq.push_back(0); gq.push_back(0);
      gq.push_back(1); gq.push_back(1); gq.push_back(1);
`else
      gq.push_back(0); gq.push_back(1); gq.push_back(0);
      gq.push_back(1); gq.push_back(0); gq.push_back(1);
`endif
      fork
         for (int k = 0; k < 3; k++) request(0, 1'b1, 8'(64 + k), 8'(192 + k), k < 2);
         for (int k = 0; k < 3; k++) request(1, 1'b1, 8'(80 + k), 8'(208 + k), k < 2);
      join
      drain();
      apply_vec(mk(1'b1, 1'b0, 8'h42, 8'h00, 8'hC2, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 0));
      apply_vec(mk(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h50, 8'h00, 8'hD0, 0));

      // Full address sweep: m0 writes i*i, m1 reads everything back.
      for (int i = 0; i < 256; i++) begin
         gq.push_back(0);
         request(0, 1'b1, 8'(i), 8'(i * i), 1'b0);
      end
      drain();
      for (int i = 0; i < 256; i++) begin
         gq.push_back(1);
         rq1.push_back(8'(i * i));
         request(1, 1'b0, 8'(i), 8'h00, 1'b0);
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
